// File: rtl/mul_issue_ctrl.sv
// Request sequencer for the 16x16 multiplier: latches operands, restarts the
// multiplier, waits for done (with timeout) and returns a saturating accumulation.
module mul_issue_ctrl #(
    parameter int ACC_W   = 40,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_x,
    input  logic [15:0]      in_y,
    input  logic             in_acc,
    input  logic             acc_clr,
    output logic [15:0]      mul_x,
    output logic [15:0]      mul_y,
    output logic             mul_clr,
    input  logic [31:0]      mul_product,
    input  logic             mul_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_err,
    output logic             busy
);

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        acc;
    } mul_req_t;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [7:0]       tcnt;
    mul_req_t         req;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] result;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign mul_x    = req.x;
    assign mul_y    = req.y;

    // One extra bit of headroom exposes the carry used for saturation.
    assign prod_ext = {{(ACC_W-32){1'b0}}, mul_product};
    assign sum      = {1'b0, acc} + {1'b0, prod_ext};

    always_comb begin
        result = prod_ext;
        if (req.acc)
            result = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            tcnt      <= '0;
            req       <= '0;
            acc       <= '0;
            mul_clr   <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    mul_clr <= 1'b0;
                    if (acc_clr)
                        acc <= '0;
                    if (in_valid) begin
                        req.x   <= in_x;
                        req.y   <= in_y;
                        req.acc <= in_acc;
                        // Registered so the restart pulse covers exactly the CLEAR cycle.
                        mul_clr <= 1'b1;
                        state   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    mul_clr <= 1'b0;
                    tcnt    <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_done) begin
                        out_data  <= result;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        acc       <= result;
                        state     <= S_RESP;
                    end else if (tcnt == TO_LAST) begin
                        out_data  <= '0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a behavioural multiplier and a
// queue-based scoreboard checked by an independent output monitor.
module tb_mul_issue_ctrl;

    localparam int ACC_W   = 33;
    localparam int TIMEOUT = 15;
    localparam int LAT     = 11;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid, in_ready, in_acc, acc_clr;
    logic [15:0]      in_x, in_y, mul_x, mul_y;
    logic             mul_clr, mul_done, out_valid, out_ready, out_err, busy;
    logic [31:0]      mul_product;
    logic [ACC_W-1:0] out_data;

    typedef struct {
        logic [ACC_W-1:0] data;
        logic             err;
        int               due;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic ov_q = 1'b0;

    mul_issue_ctrl #(.ACC_W(ACC_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .in_acc(in_acc), .acc_clr(acc_clr),
        .mul_x(mul_x), .mul_y(mul_y), .mul_clr(mul_clr),
        .mul_product(mul_product), .mul_done(mul_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: done is tuned so the result appears 11 cycles after acceptance.
    logic [3:0] dcnt;
    logic       no_done = 1'b0;
    assign mul_product = {16'b0, mul_x} * {16'b0, mul_y};
    always @(posedge clk) begin
        if (mul_clr) begin
            dcnt     <= '0;
            mul_done <= 1'b0;
        end else if (!mul_done) begin
            if (dcnt != 4'hF) dcnt <= dcnt + 4'd1;
            if (dcnt == 4'd7 && !no_done) mul_done <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: latency on the rising edge of out_valid, data/err on handshake.
    always @(negedge clk) begin
        if (out_valid && !ov_q) begin
            if (sb.size() == 0) chk("unexpected_valid", 64'(out_valid), 64'd0);
            else                chk("latency", 64'(cyc), 64'(sb[0].due));
        end
        if (out_valid && out_ready && sb.size() != 0) begin
            chk("out_data", 64'(out_data), 64'(sb[0].data));
            chk("out_err", 64'(out_err), 64'(sb[0].err));
            void'(sb.pop_front());
        end
        ov_q <= out_valid;
    end

    task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic acc,
                         input logic clr, input logic [ACC_W-1:0] d, input logic e,
                         input int lat, input bit push);
        int n;
        @(negedge clk);
        in_x = x; in_y = y; in_acc = acc; acc_clr = clr; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
        else if (push) sb.push_back('{d, e, cyc + lat});
        @(negedge clk);
        in_valid = 1'b0; acc_clr = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("response_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        reset = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_acc = 1'b0;
        acc_clr = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mul_clr", 64'(mul_clr), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_mul_xy", 64'({mul_x, mul_y}), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_mul_clr", 64'(mul_clr), 64'd0);

        // Basic op; out_valid must be a single-cycle pulse.
        issue(16'd3, 16'd5, 1'b0, 1'b0, 33'd15, 1'b0, LAT, 1'b1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("valid_pulse_len", 64'(n), 64'd1);
        wait_done();

        // Full-scale product under 5 cycles of backpressure.
        out_ready = 1'b0;
        issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 33'h0FFFE0001, 1'b0, LAT, 1'b1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_data", 64'(out_data), 64'h0FFFE0001);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        wait_done();

        // Accumulate from a cleared accumulator up to saturation.
        issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 33'h0FFFE0001, 1'b0, LAT, 1'b1);
        wait_done();
        issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 33'h1FFFC0002, 1'b0, LAT, 1'b1);
        wait_done();
        issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 33'h1FFFFFFFF, 1'b0, LAT, 1'b1);
        wait_done();

        // Timeout leaves the accumulator at 100.
        issue(16'd10, 16'd10, 1'b0, 1'b0, 33'd100, 1'b0, LAT, 1'b1);
        wait_done();
        no_done = 1'b1;
        issue(16'd9, 16'd9, 1'b1, 1'b0, 33'd0, 1'b1, 2 + TIMEOUT, 1'b1);
        wait_done();
        no_done = 1'b0;
        issue(16'd1, 16'd1, 1'b1, 1'b0, 33'd101, 1'b0, LAT, 1'b1);
        wait_done();

        // acc_clr together with a request: the op sees a zero accumulator.
        issue(16'd10, 16'd10, 1'b0, 1'b0, 33'd100, 1'b0, LAT, 1'b1);
        wait_done();
        issue(16'd2, 16'd2, 1'b1, 1'b1, 33'd4, 1'b0, LAT, 1'b1);
        wait_done();

        // Reset in the middle of WAIT discards the op and clears the accumulator.
        issue(16'd5, 16'd5, 1'b1, 1'b0, 33'd0, 1'b0, 0, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_mul_clr", 64'(mul_clr), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready", 64'(in_ready), 64'd1);
        issue(16'd7, 16'd6, 1'b1, 1'b0, 33'd42, 1'b0, LAT, 1'b1);
        wait_done();

        repeat (5) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
Request-side sequencer that sits directly upstream of the 16x16 Karatsuba multiplier and also consumes its output.
- Accepts operand pairs over a valid/ready handshake and holds them stable on the multiplier inputs.
- Restarts the multiplier through its active-high clear, then waits for done.
- Captures the 32-bit product, optionally accumulates it into a saturating accumulator, and returns the result over a valid/ready handshake.
- Flags a timeout if done never arrives.

Parameters:
ACC_W, 40, accumulator/result width (33..64).
TIMEOUT, 15, max WAIT cycles before error (1..255).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous active-low reset.
in_valid  input  1  operand request valid.
in_ready  output  1  controller can accept a request.
in_x  input  16  operand x.
in_y  input  16  operand y.
in_acc  input  1  1 = add product into accumulator; 0 = load accumulator with product.
acc_clr  input  1  synchronous accumulator clear, honoured only in IDLE.
mul_x  output  16  to multiplier x.
mul_y  output  16  to multiplier y.
mul_clr  output  1  active-high restart to multiplier reset.
mul_product  input  32  from multiplier product.
mul_done  input  1  from multiplier done (level; stays high until restart).
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_data  output  ACC_W  result (accumulator value after this op).
out_err  output  1  timeout flag, qualified by out_valid.
busy  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, CLEAR, WAIT, RESP. Encoding is implementation choice.
- Reset (reset=0, async) values:
  - state=IDLE, accumulator=0, timeout counter=0.
  - mul_x=0, mul_y=0, mul_clr=1 (the multiplier is held cleared while we are in reset).
  - out_valid=0, out_data=0, out_err=0, busy=0.
  - in_ready=1 once reset deasserts.
- IDLE:
  - in_ready=1, mul_clr=0.
  - If acc_clr=1: accumulator<=0. If in_valid is also 1 in the same cycle, the clear applies first and the new op sees accumulator=0.
  - On in_valid&in_ready: latch in_x->mul_x, in_y->mul_y, latch in_acc; go to CLEAR.
- CLEAR (exactly 1 cycle):
  - mul_clr=1, in_ready=0, timeout counter<=0.
  - Go to WAIT.
- WAIT:
  - mul_clr=0, in_ready=0; mul_x/mul_y held.
  - mul_done=1: compute result (rules below), out_data<=result, out_err<=0, out_valid<=1, go to RESP.
  - Else the counter increments. When the counter reaches TIMEOUT with mul_done still 0: out_data<=0, out_err<=1, out_valid<=1, accumulator unchanged, go to RESP.
- Arithmetic:
  - Product is zero-extended to ACC_W.
  - in_acc=0: result=product.
  - in_acc=1: result=acc+product, computed in ACC_W+1 bits. On carry out, saturate to all-ones (2^ACC_W-1).
  - Accumulator<=result on a successful op only.
- RESP:
  - out_valid stays 1; out_data and out_err are stable until accepted.
  - On out_ready=1: out_valid<=0, go to IDLE. The next request is accepted no earlier than the following cycle (no bypass).
  - out_ready while out_valid=0 is ignored.
- Latency: request accepted at cycle T gives mul_clr=1 at T+1; with the multiplier's fixed 9-cycle done latency, out_valid rises at T+11.
- in_ready is combinational from state (IDLE only).
- mul_clr is registered, so it is glitch-free.
- Reset mid-operation: immediately returns to IDLE, accumulator is cleared, and any pending result is discarded.
- in_valid held high continuously: exactly one op per IDLE visit.

Test Plan:
- The bench multiplier model returns x*y with done 9 cycles after mul_clr falls, unless stated otherwise.
- Basic op: x=3, y=5, in_acc=0, out_ready=1 -> out_data=15, out_err=0; out_valid is high for exactly 1 cycle, 11 cycles after acceptance.
- Full-scale product: x=0xFFFF, y=0xFFFF, in_acc=0 -> out_data=0x00FFFE0001. Backpressure with out_ready=0 for 5 cycles -> out_valid and out_data held, in_ready=0 throughout.
- Accumulation/saturation (ACC_W=33): three ops of 0xFFFF*0xFFFF with in_acc=1 starting from acc=0:
  - results 0x0FFFE0001, then 0x1FFFC0002, then 0x1FFFFFFFF (saturated).
- Timeout: model never asserts done -> out_valid with out_err=1, out_data=0 after TIMEOUT WAIT cycles; accumulator unchanged (check with a following in_acc=1 op, x=1, y=1).
- acc_clr with in_valid in the same IDLE cycle, prior acc=100, x=2, y=2, in_acc=1 -> out_data=4.
- Reset asserted mid-WAIT -> busy=0, out_valid=0, mul_clr=1 immediately. After release, in_ready=1 and the next op x=7, y=6, in_acc=1 -> out_data=42.
